// File: rtl/flash_fetch_cache_pkg.sv
// Shared types and sizing helpers for the flash instruction-fetch cache.
package flash_fetch_cache_pkg;

    localparam int unsigned ADDR_W_DEF     = 24;
    localparam int unsigned INDEX_BITS_DEF = 5;
    localparam int unsigned DATA_W         = 32;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL
    } state_t;

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned index_bits);
        return addr_w - index_bits;
    endfunction

endpackage

// File: rtl/fetch_cache_ram.sv
// Single-port line store with one-cycle synchronous read; a write cycle skips the read.
module fetch_cache_ram #(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned WIDTH      = 51
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 2 ** INDEX_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/flash_fetch_cache.sv
// Direct-mapped, one-word-per-line instruction cache in front of the quad-SPI flash reader.
module flash_fetch_cache
    import flash_fetch_cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_start,
    input  logic              flush,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_done,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] spi_addr,
    output logic              spi_start,
    input  logic [DATA_W-1:0] spi_instr,
    input  logic              spi_init_done,
    input  logic              spi_recv_done
);

    localparam int unsigned TAG_W  = tag_width(ADDR_W, INDEX_BITS);
    localparam int unsigned LINE_W = DATA_W + TAG_W;
    localparam int unsigned LINES  = 2 ** INDEX_BITS;

    state_t                  state;
    logic [ADDR_W-1:0]       req_addr;
    logic [LINES-1:0]        valid;
    logic                    flush_pending;

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_BITS-1:0]   ram_addr;
    logic [LINE_W-1:0]       ram_wdata;
    logic [LINE_W-1:0]       ram_rdata;
    logic                    ram_we;
    logic [TAG_W-1:0]        line_tag;
    logic [DATA_W-1:0]       line_data;
    logic                    hit;
    logic                    flush_apply_c;

    assign req_idx       = req_addr[INDEX_BITS-1:0];
    assign req_tag       = req_addr[ADDR_W-1:INDEX_BITS];
    assign ram_we        = (state == ST_FILL) && spi_recv_done && spi_init_done && !reset;
    assign ram_addr      = (state == ST_FILL) ? req_idx : cpu_addr[INDEX_BITS-1:0];
    assign ram_wdata     = {req_tag, spi_instr};
    assign {line_tag, line_data} = ram_rdata;
    assign hit           = valid[req_idx] && (line_tag == req_tag);
    assign flush_apply_c = flush || flush_pending;

    fetch_cache_ram #(
        .INDEX_BITS (INDEX_BITS),
        .WIDTH      (LINE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Flushes seen while busy are deferred and applied on the edge that re-enters IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_INIT;
            req_addr      <= '0;
            valid         <= '0;
            flush_pending <= 1'b0;
            cpu_q         <= '0;
            cpu_done      <= 1'b0;
            cpu_busy      <= 1'b1;
            spi_addr      <= '0;
            spi_start     <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            if (flush && state != ST_IDLE) begin
                flush_pending <= 1'b1;
            end
            if (state != ST_INIT && !spi_init_done) begin
                state     <= ST_INIT;
                cpu_busy  <= 1'b1;
                spi_start <= 1'b0;
            end else begin
                case (state)
                    ST_INIT: begin
                        if (spi_init_done) begin
                            state    <= ST_IDLE;
                            cpu_busy <= 1'b0;
                            if (flush_apply_c) begin
                                valid         <= '0;
                                flush_pending <= 1'b0;
                            end
                        end
                    end
                    ST_IDLE: begin
                        if (flush) begin
                            valid <= '0;
                        end else if (cpu_start) begin
                            req_addr <= cpu_addr;
                            cpu_busy <= 1'b1;
                            state    <= ST_LOOKUP;
                        end
                    end
                    ST_LOOKUP: begin
                        if (hit) begin
                            cpu_q    <= line_data;
                            cpu_done <= 1'b1;
                            cpu_busy <= 1'b0;
                            state    <= ST_IDLE;
                            if (flush_apply_c) begin
                                valid         <= '0;
                                flush_pending <= 1'b0;
                            end
                        end else begin
                            spi_addr  <= req_addr;
                            spi_start <= 1'b1;
                            state     <= ST_FILL;
                        end
                    end
                    ST_FILL: begin
                        if (spi_recv_done) begin
                            valid[req_idx] <= 1'b1;
                            cpu_q          <= spi_instr;
                            cpu_done       <= 1'b1;
                            cpu_busy       <= 1'b0;
                            spi_start      <= 1'b0;
                            state          <= ST_IDLE;
                            if (flush_apply_c) begin
                                valid         <= '0;
                                flush_pending <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= ST_INIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_fetch_cache.sv
// Randomized self-checking bench for flash_fetch_cache against an address-level cache model.
module tb_flash_fetch_cache;

    localparam int unsigned ADDR_W     = 24;
    localparam int unsigned INDEX_BITS = 5;
    localparam int unsigned LINES      = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_start;
    logic              flush;
    logic [31:0]       cpu_q;
    logic              cpu_done;
    logic              cpu_busy;
    logic [ADDR_W-1:0] spi_addr;
    logic              spi_start;
    logic [31:0]       spi_instr;
    logic              spi_init_done;
    logic              spi_recv_done;

    int checks   = 0;
    int failures = 0;

    // Model: each line remembers the full word address it holds and the word returned for it.
    bit                mv [LINES];
    logic [ADDR_W-1:0] ma [LINES];
    logic [31:0]       md [LINES];

    flash_fetch_cache #(
        .ADDR_W     (ADDR_W),
        .INDEX_BITS (INDEX_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_addr      (cpu_addr),
        .cpu_start     (cpu_start),
        .flush         (flush),
        .cpu_q         (cpu_q),
        .cpu_done      (cpu_done),
        .cpu_busy      (cpu_busy),
        .spi_addr      (spi_addr),
        .spi_start     (spi_start),
        .spi_instr     (spi_instr),
        .spi_init_done (spi_init_done),
        .spi_recv_done (spi_recv_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_invalidate_all();
        for (int i = 0; i < int'(LINES); i++) mv[i] = 1'b0;
    endfunction

    // One CPU fetch; the cache model decides hit or miss and what the CPU must see.
    task automatic fetch(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                         input int lat, input bit flush_mid, input bit stray);
        int idx;
        bit exp_hit;
        bit hold_ok;
        idx     = int'(addr % LINES);
        exp_hit = mv[idx] && (ma[idx] == addr);
        @(negedge clk);
        check_eq("idle_busy", 32'(cpu_busy), 32'd0);
        cpu_addr      = addr;
        cpu_start     = 1'b1;
        spi_recv_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cpu_start = stray;
        if (stray) begin
            cpu_addr      = addr ^ 24'h000101;
            spi_recv_done = 1'b1;
            spi_instr     = 32'hBAD0_BAD0;
        end
        @(posedge clk);
        #1;
        if (exp_hit) begin
            check_eq("hit_done", 32'(cpu_done), 32'd1);
            check_eq("hit_q", cpu_q, md[idx]);
            check_eq("hit_no_spi", 32'(spi_start), 32'd0);
        end else begin
            check_eq("miss_no_done", 32'(cpu_done), 32'd0);
            check_eq("miss_spi_start", 32'(spi_start), 32'd1);
            check_eq("miss_spi_addr", 32'(spi_addr), 32'(addr));
            hold_ok = 1'b1;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                cpu_start     = 1'b0;
                spi_recv_done = 1'b0;
                flush         = flush_mid && (i == lat / 2);
                if (!spi_start || cpu_done || spi_addr != addr) hold_ok = 1'b0;
            end
            @(negedge clk);
            cpu_start     = 1'b0;
            flush         = 1'b0;
            spi_recv_done = 1'b1;
            spi_instr     = data;
            @(posedge clk);
            #1;
            check_eq("fill_hold", 32'(hold_ok), 32'd1);
            check_eq("fill_done", 32'(cpu_done), 32'd1);
            check_eq("fill_q", cpu_q, data);
            check_eq("fill_spi_drop", 32'(spi_start), 32'd0);
            mv[idx] = 1'b1;
            ma[idx] = addr;
            md[idx] = data;
            if (flush_mid && lat > 0) model_invalidate_all();
            @(negedge clk);
            spi_recv_done = 1'b0;
            spi_instr     = $urandom;
        end
        cpu_start = 1'b0;
    endtask

    // Flush in IDLE wins over a simultaneous request, which must not be accepted.
    task automatic idle_flush(input logic [ADDR_W-1:0] addr);
        @(negedge clk);
        flush     = 1'b1;
        cpu_start = 1'b1;
        cpu_addr  = addr;
        @(posedge clk);
        #1;
        check_eq("flush_not_accepted", 32'(cpu_busy), 32'd0);
        model_invalidate_all();
        @(negedge clk);
        flush     = 1'b0;
        cpu_start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("flush_no_done", 32'(cpu_done), 32'd0);
    endtask

    // Starts a miss and stops once the DUT is requesting the flash.
    task automatic start_miss(input logic [ADDR_W-1:0] addr);
        @(negedge clk);
        cpu_addr  = addr;
        cpu_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_spi_start", 32'(spi_start), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] tag_pool [4];
        bit          ok_busy;
        bit          ok_spi;
        bit          no_done;
        tag_pool[0] = 19'h00000;
        tag_pool[1] = 19'h00001;
        tag_pool[2] = 19'h2A5A5;
        tag_pool[3] = 19'h7FFFF;

        reset         = 1'b1;
        cpu_addr      = '0;
        cpu_start     = 1'b0;
        flush         = 1'b0;
        spi_instr     = '0;
        spi_init_done = 1'b0;
        spi_recv_done = 1'b0;
        model_invalidate_all();

        // Reset values, then the reader not yet initialised for 10 cycles.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_q", cpu_q, 32'd0);
        check_eq("rst_done", 32'(cpu_done), 32'd0);
        check_eq("rst_spi_addr", 32'(spi_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ok_busy = 1'b1;
        ok_spi  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!cpu_busy) ok_busy = 1'b0;
            if (spi_start) ok_spi = 1'b0;
        end
        check_eq("init_busy", 32'(ok_busy), 32'd1);
        check_eq("init_no_spi", 32'(ok_spi), 32'd0 + 32'(1'b1));
        @(negedge clk);
        spi_init_done = 1'b1;
        @(posedge clk);
        #1;
        check_eq("init_ready", 32'(cpu_busy), 32'd0);

        // Cold miss, hit, conflicting tag, re-miss.
        fetch(24'h000010, 32'hDEADBEEF, 24, 1'b0, 1'b0);
        fetch(24'h000010, 32'h0, 0, 1'b0, 1'b0);
        fetch(24'h000030, 32'h12345678, 5, 1'b0, 1'b1);
        fetch(24'h000010, 32'hDEADBEEF, 7, 1'b0, 1'b0);

        // Flush during a fill still completes the fill, then the line is gone.
        fetch(24'h000044, 32'hA5A5_0044, 10, 1'b1, 1'b0);
        fetch(24'h000044, 32'h5A5A_0044, 3, 1'b0, 1'b0);

        // Reader drops init mid-fill: fill abandoned, cached lines survive.
        fetch(24'h000010, 32'h0BAD_F00D, 4, 1'b0, 1'b0);
        start_miss(24'h000055);
        @(negedge clk);
        spi_init_done = 1'b0;
        @(posedge clk);
        #1;
        check_eq("drop_spi_start", 32'(spi_start), 32'd0);
        check_eq("drop_busy", 32'(cpu_busy), 32'd1);
        repeat (3) @(negedge clk);
        spi_init_done = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reinit_ready", 32'(cpu_busy), 32'd0);
        fetch(24'h000010, 32'h0, 0, 1'b0, 1'b0);

        // Synchronous reset during a fill, with a completion arriving on the reset edge.
        start_miss(24'h000077);
        @(negedge clk);
        reset         = 1'b1;
        spi_recv_done = 1'b1;
        spi_instr     = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check_eq("rst_fill_spi", 32'(spi_start), 32'd0);
        check_eq("rst_fill_busy", 32'(cpu_busy), 32'd1);
        model_invalidate_all();
        @(negedge clk);
        reset         = 1'b0;
        spi_recv_done = 1'b0;
        no_done       = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (cpu_done) no_done = 1'b0;
        end
        check_eq("rst_fill_no_done", 32'(no_done), 32'd1);
        fetch(24'h000077, 32'h7777_0077, 6, 1'b0, 1'b0);
        fetch(24'h000010, 32'h1010_0010, 2, 1'b0, 1'b0);

        // Random traffic over a few tags per index to mix hits, conflicts and flushes.
        for (int n = 0; n < 150; n++) begin
            logic [ADDR_W-1:0] a;
            a = {tag_pool[$urandom_range(0, 3)], 5'($urandom_range(0, 7))};
            if ($urandom_range(0, 11) == 0) begin
                idle_flush(a);
            end else begin
                fetch(a, $urandom, int'($urandom_range(1, 12)),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
